// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT butterfly sequencer: default sizes, derived widths and the
// sequencer state type.
package fft_seq_pkg;

   localparam int unsigned N_POINTS = 64;
   localparam int unsigned LOG2_N   = 6;
   localparam int unsigned BF_W     = LOG2_N - 1;
   localparam int unsigned STG_W    = 3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } fft_seq_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 pair address and twiddle index decode from (stage, butterfly number).
module fft_addr_gen
   import fft_seq_pkg::*;
#(
   parameter int unsigned Log2N = LOG2_N
) (
   input  logic [STG_W-1:0] stage_i,
   input  logic [Log2N-2:0] b_i,
   output logic [Log2N-1:0] idx_a_o,
   output logic [Log2N-1:0] idx_b_o,
   output logic [Log2N-2:0] tw_idx_o
);

   localparam logic [STG_W-1:0] TwTop = STG_W'(Log2N - 1);

   logic [Log2N-1:0] b_ext;
   logic [Log2N-1:0] span;
   logic [Log2N-1:0] hi;
   logic [Log2N-1:0] low;
   logic [Log2N-1:0] idx_a;
   logic [Log2N-2:0] mask;
   logic [Log2N-2:0] low_n;

   assign b_ext = {1'b0, b_i};
   assign span  = {{(Log2N-1){1'b0}}, 1'b1} << stage_i;
   assign mask  = ~({(Log2N-1){1'b1}} << stage_i);
   assign low_n = b_i & mask;
   assign low   = {1'b0, low_n};

   // Group number is moved up one bit to leave room for the pair's span bit.
   assign hi    = (b_ext >> stage_i) << (stage_i + STG_W'(1));
   assign idx_a = hi | low;

   assign idx_a_o  = idx_a;
   assign idx_b_o  = idx_a + span;
   assign tw_idx_o = low_n << (TwTop - stage_i);

endmodule

// File: rtl/fft_sequencer.sv
// Frame handshake and stage/butterfly sequencing for the in-place radix-2 FFT datapath.
// State advances on the falling clock edge, the same edge the datapath samples on.
module fft_sequencer
   import fft_seq_pkg::*;
#(
   parameter int unsigned NPoints = N_POINTS,
   parameter int unsigned Log2N   = LOG2_N
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             load_o,
   output logic             bf_en_o,
   output logic [STG_W-1:0] stage_o,
   output logic [Log2N-1:0] idx_a_o,
   output logic [Log2N-1:0] idx_b_o,
   output logic [Log2N-2:0] tw_idx_o,
   output logic             busy_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   input  logic             abort_i,
   output logic [7:0]       frame_cnt_o
);

   localparam logic [Log2N-2:0]  BLast = (Log2N-1)'(NPoints / 2 - 1);
   localparam logic [Log2N-2:0]  BOne  = (Log2N-1)'(1);
   localparam logic [STG_W-1:0]  SLast = STG_W'(Log2N - 1);
   localparam logic [STG_W-1:0]  SOne  = STG_W'(1);

   fft_seq_state_t   state_q, state_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic [Log2N-2:0] b_q, b_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   logic             run;
   logic [Log2N-1:0] gen_idx_a;
   logic [Log2N-1:0] gen_idx_b;
   logic [Log2N-2:0] gen_tw_idx;

   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      b_d         = b_q;
      frame_cnt_d = frame_cnt_q;
      if (abort_i) begin
         state_d = StIdle;
         stage_d = '0;
         b_d     = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  state_d = StRun;
                  stage_d = '0;
                  b_d     = '0;
               end
            end
            StRun: begin
               if (b_q == BLast) begin
                  b_d = '0;
                  if (stage_q == SLast) begin
                     state_d = StDone;
                     stage_d = '0;
                  end else begin
                     stage_d = stage_q + SOne;
                  end
               end else begin
                  b_d = b_q + BOne;
               end
            end
            StDone: begin
               if (out_ready_i) begin
                  state_d     = StIdle;
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         stage_q     <= '0;
         b_q         <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         b_q         <= b_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   fft_addr_gen #(
      .Log2N (Log2N)
   ) u_addr_gen (
      .stage_i  (stage_q),
      .b_i      (b_q),
      .idx_a_o  (gen_idx_a),
      .idx_b_o  (gen_idx_b),
      .tw_idx_o (gen_tw_idx)
   );

   assign run         = (state_q == StRun);
   assign in_ready_o  = (state_q == StIdle);
   assign load_o      = in_valid_i & in_ready_o & ~abort_i;
   assign bf_en_o     = run;
   assign busy_o      = run;
   assign out_valid_o = (state_q == StDone);
   assign frame_cnt_o = frame_cnt_q;

   // Address outputs read as zero whenever the engine is not stepping.
   assign stage_o  = run ? stage_q    : '0;
   assign idx_a_o  = run ? gen_idx_a  : '0;
   assign idx_b_o  = run ? gen_idx_b  : '0;
   assign tw_idx_o = run ? gen_tw_idx : '0;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: inputs driven and outputs sampled on the rising edge,
// away from the falling edge that advances the sequencer.
module tb_fft_sequencer;

   logic       clk = 1'b1;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       abort = 1'b0;
   logic       in_ready, load, bf_en, busy, out_valid;
   logic [2:0] stage;
   logic [5:0] idx_a, idx_b;
   logic [4:0] tw_idx;
   logic [7:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fft_sequencer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .load_o      (load),
      .bf_en_o     (bf_en),
      .stage_o     (stage),
      .idx_a_o     (idx_a),
      .idx_b_o     (idx_b),
      .tw_idx_o    (tw_idx),
      .busy_o      (busy),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .abort_i     (abort),
      .frame_cnt_o (frame_cnt)
   );

   task automatic step();
      @(posedge clk);
   endtask

   // Raise in_valid for one cycle; returns at RUN cycle 0 (one rising edge after the handshake).
   task automatic start_frame(input string tag);
      in_valid = 1'b1;
      #1;
      checks++;
      if (load !== 1'b1) begin
         errors++;
         $display("FAIL %s_load_pulse: got %b want 1", tag, load);
      end
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (load !== 1'b0) begin
         errors++;
         $display("FAIL %s_load_drop: got %b want 0", tag, load);
      end
   endtask

   // Counts consecutive bf_en cycles (bounded); returns on the first edge with bf_en low.
   task automatic wait_run(output int n);
      n = 0;
      while (bf_en === 1'b1 && n < 300) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      #1;
      checks++;
      if ({in_ready, load, bf_en, busy, out_valid} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 10000", {in_ready, load, bf_en, busy, out_valid});
      end
      checks++;
      if ({stage, idx_a, idx_b, tw_idx} !== 20'd0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 0", {stage, idx_a, idx_b, tw_idx});
      end
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
      end
      in_valid = 1'b1;
      #1;
      checks++;
      if (load !== 1'b1) begin
         errors++;
         $display("FAIL reset_load_comb: got %b want 1", load);
      end
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_frame();
      int n;
      start_frame("single");
      wait_run(n);
      checks++;
      if (n != 192) begin
         errors++;
         $display("FAIL single_bf_cycles: got %0d want 192", n);
      end
      checks++;
      if ({out_valid, busy} !== 2'b10) begin
         errors++;
         $display("FAIL single_out_valid: got %b want 10", {out_valid, busy});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if ({frame_cnt, in_ready, out_valid} !== {8'd1, 2'b10}) begin
         errors++;
         $display("FAIL single_complete: got cnt=%0d rdy=%b ov=%b want cnt=1 rdy=1 ov=0",
                  frame_cnt, in_ready, out_valid);
      end
   endtask

   task automatic test_address_sweep();
      logic [63:0] seen;
      int span, grp, j, ea, eb, et;
      start_frame("sweep");
      for (int s = 0; s < 6; s++) begin
         seen = '0;
         for (int b = 0; b < 32; b++) begin
            span = 1 << s;
            grp  = b / span;
            j    = b % span;
            ea   = grp * 2 * span + j;
            eb   = ea + span;
            et   = j * (32 / span);
            checks++;
            if ({bf_en, stage, idx_a, idx_b, tw_idx} !== {1'b1, 3'(s), 6'(ea), 6'(eb), 5'(et)}) begin
               errors++;
               $display("FAIL sweep_pair s%0d b%0d: got en=%b st=%0d a=%0d b=%0d tw=%0d want 1 %0d %0d %0d %0d",
                        s, b, bf_en, stage, idx_a, idx_b, tw_idx, s, ea, eb, et);
            end
            if (s == 0 && b == 5) begin
               checks++;
               if ({idx_a, idx_b, tw_idx} !== {6'd10, 6'd11, 5'd0}) begin
                  errors++;
                  $display("FAIL sweep_s0b5: got %0d %0d %0d want 10 11 0", idx_a, idx_b, tw_idx);
               end
            end
            if (s == 3 && b == 13) begin
               checks++;
               if ({idx_a, idx_b, tw_idx} !== {6'd21, 6'd29, 5'd20}) begin
                  errors++;
                  $display("FAIL sweep_s3b13: got %0d %0d %0d want 21 29 20", idx_a, idx_b, tw_idx);
               end
            end
            if (s == 5 && b == 31) begin
               checks++;
               if ({idx_a, idx_b, tw_idx} !== {6'd31, 6'd63, 5'd31}) begin
                  errors++;
                  $display("FAIL sweep_s5b31: got %0d %0d %0d want 31 63 31", idx_a, idx_b, tw_idx);
               end
            end
            seen[idx_a] = 1'b1;
            seen[idx_b] = 1'b1;
            step();
         end
         checks++;
         if (seen !== {64{1'b1}}) begin
            errors++;
            $display("FAIL sweep_coverage s%0d: got %h want all ones", s, seen);
         end
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL sweep_out_valid: got %b want 1", out_valid);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if (frame_cnt !== 8'd2) begin
         errors++;
         $display("FAIL sweep_frame_cnt: got %0d want 2", frame_cnt);
      end
   endtask

   task automatic test_backpressure();
      int n;
      start_frame("bp");
      wait_run(n);
      for (int i = 0; i < 50; i++) begin
         in_valid = i[0];
         #1;
         checks++;
         if ({out_valid, bf_en, in_ready, load, frame_cnt} !== {4'b1000, 8'd2}) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: got ov=%b en=%b rdy=%b ld=%b cnt=%0d want 1 0 0 0 2",
                     i, out_valid, bf_en, in_ready, load, frame_cnt);
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      #1;
      checks++;
      if ({frame_cnt, in_ready} !== {8'd3, 1'b1}) begin
         errors++;
         $display("FAIL bp_release: got cnt=%0d rdy=%b want cnt=3 rdy=1", frame_cnt, in_ready);
      end
      step();
      checks++;
      if (frame_cnt !== 8'd3) begin
         errors++;
         $display("FAIL bp_single_inc: got %0d want 3", frame_cnt);
      end
   endtask

   task automatic test_abort();
      int n;
      int ov_seen;
      start_frame("abort");
      repeat (100) step();
      abort = 1'b1;
      #1;
      checks++;
      if (bf_en !== 1'b1) begin
         errors++;
         $display("FAIL abort_bf_en_cycle: got %b want 1", bf_en);
      end
      step();
      abort = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, bf_en, stage} !== {3'b100, 3'd0}) begin
         errors++;
         $display("FAIL abort_to_idle: got rdy=%b busy=%b en=%b st=%0d want 1 0 0 0",
                  in_ready, busy, bf_en, stage);
      end
      ov_seen = 0;
      repeat (250) begin
         step();
         if (out_valid === 1'b1) ov_seen++;
      end
      checks++;
      if (ov_seen != 0 || frame_cnt !== 8'd3) begin
         errors++;
         $display("FAIL abort_no_output: got ov_cycles=%0d cnt=%0d want 0 3", ov_seen, frame_cnt);
      end
      in_valid = 1'b1;
      abort = 1'b1;
      #1;
      checks++;
      if (load !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_load: got %b want 0", load);
      end
      step();
      in_valid = 1'b0;
      abort = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL abort_idle_stay: got rdy=%b busy=%b want 1 0", in_ready, busy);
      end
      start_frame("abort_done");
      wait_run(n);
      out_ready = 1'b1;
      abort = 1'b1;
      step();
      out_ready = 1'b0;
      abort = 1'b0;
      #1;
      checks++;
      if ({frame_cnt, in_ready, out_valid} !== {8'd3, 2'b10}) begin
         errors++;
         $display("FAIL abort_done_no_inc: got cnt=%0d rdy=%b ov=%b want 3 1 0",
                  frame_cnt, in_ready, out_valid);
      end
   endtask

   task automatic test_async_reset();
      start_frame("areset");
      repeat (67) step();
      checks++;
      if (stage !== 3'd2) begin
         errors++;
         $display("FAIL areset_pre_stage: got %0d want 2", stage);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, bf_en, out_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL areset_flags: got %b want 1000", {in_ready, busy, bf_en, out_valid});
      end
      checks++;
      if ({stage, idx_a, idx_b, tw_idx, frame_cnt} !== 28'd0) begin
         errors++;
         $display("FAIL areset_values: got %h want 0", {stage, idx_a, idx_b, tw_idx, frame_cnt});
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Back-to-back frames with both handshakes held high; each frame occupies 194 edges.
   task automatic test_counter_wrap();
      int nbf;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int f = 0; f < 256; f++) begin
         #1;
         checks++;
         if (load !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load f%0d: got %b want 1", f, load);
         end
         nbf = 0;
         for (int k = 1; k <= 194; k++) begin
            step();
            if (k <= 193 && bf_en === 1'b1) nbf++;
         end
         checks++;
         if (nbf != 192 || in_ready !== 1'b1 || frame_cnt !== 8'((f + 1) % 256)) begin
            errors++;
            $display("FAIL wrap_frame f%0d: got bf=%0d rdy=%b cnt=%0d want 192 1 %0d",
                     f, nbf, in_ready, frame_cnt, (f + 1) % 256);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL wrap_final: got %0d want 0", frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_address_sweep();
      test_backpressure();
      test_abort();
      test_async_reset();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
